// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard control: load-use stall, branch flush, forwarding, data-memory wait FSM
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic              wb_regwrite,
    input  logic              mem_access,
    input  logic              dmem_ack,
    input  logic              br_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              bubble_ex,
    output logic              bubble_wb,
    output logic              flush_if,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              mem_err,
    output logic              busy,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  wait_cnt_tot
);

    localparam int          WCW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned WLAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WCW-1:0] WLAST = WCW'(WLAST_I);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t         state_q;
    logic [WCW-1:0] wcnt_q;
    logic           br_pend_q;
    logic           abort;
    logic           freeze;
    logic           load_use;
    logic           br_eff;
    logic           unused_ok;

    assign unused_ok = &{1'b0, ex_regwrite};

    assign abort    = (state_q == ST_WAIT) && (TIMEOUT != 0) && (wcnt_q == WLAST);
    assign freeze   = mem_access & ~dmem_ack & ~abort;
    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    // A redirect that arrived while frozen is remembered so it still flushes once MEM moves on.
    assign br_eff   = br_taken | br_pend_q;

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        bubble_ex = 1'b0;
        bubble_wb = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        if (freeze) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
        end else if (br_eff) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    assign mem_err = abort;
    assign busy    = (state_q == ST_WAIT);

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_regwrite && !mem_memread && (mem_rd != '0) && (mem_rd == ex_rs1))
            fwd_a = 2'b01;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1))
            fwd_a = 2'b10;
        if (mem_regwrite && !mem_memread && (mem_rd != '0) && (mem_rd == ex_rs2))
            fwd_b = 2'b01;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2))
            fwd_b = 2'b10;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_RUN;
            wcnt_q    <= '0;
            br_pend_q <= 1'b0;
        end else begin
            br_pend_q <= freeze & br_eff;
            case (state_q)
                ST_RUN: begin
                    wcnt_q <= '0;
                    if (mem_access && !dmem_ack)
                        state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dmem_ack || abort) begin
                        state_q <= ST_RUN;
                        wcnt_q  <= '0;
                    end else begin
                        wcnt_q <= wcnt_q + WCW'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    wcnt_q  <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] wait_cnt_q;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (bubble_ex && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_if && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (stall_mem && (wait_cnt_q != '1))
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign wait_cnt_tot = wait_cnt_q;
`else
    assign stall_cnt    = '0;
    assign flush_cnt    = '0;
    assign wait_cnt_tot = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width (4 selects RV32E).
REQ-002 SHALL have parameter TIMEOUT, default 16, max data-memory wait cycles before abort; 0 disables the watchdog.
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports first: Clk input 1, rising-edge clock; Rst input 1, async active-low reset.
REQ-005 SHALL have ID-stage inputs: id_rs1, id_rs2 input REG_AW, ID source regs; id_use_rs1, id_use_rs2 input 1, source actually read.
REQ-006 SHALL have EX-stage inputs: ex_rs1, ex_rs2, ex_rd input REG_AW; ex_regwrite, ex_memread input 1.
REQ-007 SHALL have MEM/WB inputs: mem_rd, wb_rd input REG_AW; mem_regwrite, mem_memread, wb_regwrite input 1; mem_access input 1, MEM-stage load/store; dmem_ack input 1, memory done; br_taken input 1, MEM-stage redirect (PCSrc).
REQ-008 SHALL have outputs: stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_if, flush_id, flush_ex, mem_err, busy, each 1; fwd_a, fwd_b output 2 (00 reg file, 01 MEM ALU result, 10 WB data).
REQ-009 SHALL have outputs stall_cnt, flush_cnt, wait_cnt_tot, each CNT_W, performance counters.

Function
REQ-010 SHALL define freeze = mem_access & ~dmem_ack & ~abort, where abort = (state==WAIT) & (TIMEOUT!=0) & (wcnt==TIMEOUT-1).
REQ-011 SHALL define load_use = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-012 SHALL apply priority freeze > br_taken > load_use; all outputs combinational in the same cycle.
REQ-013 freeze SHALL assert stall_if/id/ex/mem=1, bubble_wb=1, all flush and bubble_ex 0.
REQ-014 br_taken (no freeze) SHALL assert flush_if/id/ex=1 and all stalls 0; a branch held under freeze SHALL flush on the first unfrozen cycle.
REQ-015 load_use (no freeze, no br_taken) SHALL assert stall_if=stall_id=bubble_ex=1 for exactly one cycle per load.
REQ-016 fwd_a SHALL be 01 if mem_regwrite & ~mem_memread & mem_rd!=0 & mem_rd==ex_rs1; else 10 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1; else 00; fwd_b identical using ex_rs2.
REQ-017 FSM states RUN, WAIT: RUN->WAIT when mem_access & ~dmem_ack; WAIT->RUN on dmem_ack or abort; ack in the request cycle keeps RUN with zero stall.
REQ-018 wcnt SHALL clear on entering WAIT, increment each WAIT cycle, and clear on return to RUN.
REQ-019 mem_err SHALL be 1 exactly in the abort cycle; the MEM access is then retired with no stall.
REQ-020 busy SHALL equal (state==WAIT).
REQ-021 With all inputs 0, every output SHALL be 0.

Reset
REQ-022 Rst low SHALL asynchronously force state=RUN, wcnt=0 and all counters 0, including mid-WAIT.
REQ-023 First rising Clk after Rst release SHALL evaluate normally; no extra bubble.

Configuration
REQ-024 Macro PIPE_HAZARD_PERF_CNT_EN defined: stall_cnt +1 per load_use cycle, flush_cnt +1 per br_taken flush cycle, wait_cnt_tot +1 per freeze cycle, each saturating at all-ones.
REQ-025 Macro undefined: counter outputs SHALL be constant 0 and no counter flops instantiated.

Verification
REQ-026 ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> stall_if=stall_id=bubble_ex=1 one cycle; same with id_use_rs2=0 or ex_rd=0 -> no stall.
REQ-027 mem_regwrite=1, mem_rd=wb_rd=7, wb_regwrite=1, ex_rs1=7 -> fwd_a=01; set mem_memread=1 -> fwd_a=10.
REQ-028 mem_access=1, dmem_ack low 3 cycles then high -> freeze/busy 3 cycles, busy low after ack, mem_err stays 0.
REQ-029 TIMEOUT=4, mem_access=1, dmem_ack=0 forever -> freeze cycles 1-4, mem_err=1 and freeze=0 in cycle 5 (wcnt==3), state RUN.
REQ-030 br_taken=1 with load_use=1 -> flush_if/id/ex=1, bubble_ex=0; br_taken=1 during freeze -> flushes deferred to release cycle.
REQ-031 Rst low in WAIT after 2 wait cycles -> busy=0 immediately, counters 0; with PIPE_HAZARD_PERF_CNT_EN, CNT_W=2, 5 load-use cycles -> stall_cnt=3.
